// File: rtl/fetch_unit_pkg.sv
// Shared core constants and the fetch-queue entry type.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {PC, instruction}; flush empties it, and a push into a
// full queue is accepted when the head pops in the same cycle.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = entries[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage is not reset; count gates every read, so only control state needs it.
    always_ff @(posedge clock) begin
        if (do_push && !(reset || flush)) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, sequential imem requests, redirect/flush,
// and a 2-entry queue feeding decode over valid/ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] target_PC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] PC
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] pc_hold;
    logic            inflight;
    logic            discard;
    logic [1:0]      count;
    logic [2:0]      occupancy;
    logic            pop;
    logic            push;
    logic            issue;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign pop = instr_valid && instr_ready;

    // Slots already claimed (queued + in flight) after this cycle's pop;
    // a pop always has count >= 1, so this cannot underflow.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = !reset && !redirect && (occupancy < 3'd2);

    // Redirect drops the response arriving this cycle along with the queue.
    assign push      = inflight && !discard && !redirect && !reset;
    assign push_data = '{pc: req_pc, instr: imem_rdata};

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != 2'd0);
    assign instruction = instr_valid ? head.instr : NOP;
    assign PC          = instr_valid ? head.pc : pc_hold;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            pc_hold  <= RESET_PC;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect) begin
                fetch_pc <= word_align(target_PC);
                discard  <= inflight;
            end else begin
                discard <= 1'b0;
                if (issue) fetch_pc <= fetch_pc + 32'd4;
            end
            if (issue)       req_pc  <= fetch_pc;
            if (instr_valid) pc_hold <= head.pc;
        end
    end

    fetch_buffer u_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V core, directly upstream of `decode`. Holds the fetch PC, issues sequential word requests to a synchronous instruction memory, buffers returned words with their PCs in a 2-entry queue, and presents them to decode under a valid/ready handshake. Taken branches and jumps from execute redirect the PC and flush all younger work. When no instruction is valid, decode sees the canonical NOP.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013 (`addi zero, zero, 0`), instruction driven when `instr_valid`=0
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `redirect`  in  1  taken branch/jump from execute
- `target_PC`  in  32  redirect destination
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  32  word-aligned request address
- `imem_rdata`  in  32  read data, valid exactly one cycle after the request
- `instr_valid`  out  1  `instruction`/`PC` are a real fetched instruction
- `instr_ready`  in  1  decode accepts the head this cycle
- `instruction`  out  32  head instruction, or `NOP` when invalid
- `PC`  out  32  address of `instruction`

## Operation
- State: `fetch_PC` (32), `inflight` (1 bit, request issued last cycle), `discard` (1 bit), 2-entry queue of {PC, instruction} with `count` 0..2.
- Pop: `instr_valid && instr_ready`.
- Issue rule: `imem_req`=1 iff not `reset`, not `redirect`, and `count + inflight - pop < 2`. On issue: `imem_addr`=`fetch_PC`, `fetch_PC` += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Return: when `inflight`=1 and `discard`=0, push {request address, `imem_rdata`} at end of that cycle. Simultaneous push and pop is legal at any `count`, including full (2).
- Redirect (highest priority after reset): flush queue (`count`<=0), `fetch_PC`<={`target_PC`[31:2],2'b00} (low bits forced to zero), set `discard` if a request is in flight, `imem_req`=0 that cycle. A pop coincident with redirect is discarded; decode must not see it as accepted (execute flushes it).
- `discard` clears when its response cycle passes.
- Redirect on consecutive cycles: the last one wins.
- `instr_valid` = (`count` != 0); `instruction`=`NOP` when invalid; `PC` holds its last value when invalid.

## Timing
- Reset values: `fetch_PC`=`RESET_PC`, `count`=0, `inflight`=0, `discard`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instruction`=`NOP`, `PC`=`RESET_PC`.
- Reset mid-operation overrides everything, including a concurrent redirect; in-flight data is dropped.
- Cycle R is the first cycle with `reset`=0: request `RESET_PC` in R, data in R+1, `instr_valid`=1 in R+2. Request-to-valid latency is 2 cycles.
- Redirect in cycle T: first request at target in T+1; target valid at decode in T+3. Penalty is 2 bubbles beyond the normal latency.
- With `instr_ready` held high, throughput is 1 instruction/cycle with no bubbles.
- With `instr_ready`=0, at most 2 words are buffered and nothing is lost. After refill, issue resumes the cycle a pop frees a slot.

## Structure
- Shared core package: `NOP`, `RESET_PC` default, `XLEN`=32.
- Sub-module `fetch_buffer`: 2-entry synchronous FIFO of 64-bit {PC, instruction} with push, pop, flush, and count. It provides the head, `count`, and push-while-full-with-pop support.
- Remaining logic stays in `fetch_unit`: PC register, issue rule, and the `inflight`/`discard` flags.

## Test plan
- Reset then `instr_ready`=1, memory returns `addr` as data: `PC`=0,4,8,12 on consecutive cycles from R+2, `instruction` equals `PC`, no bubbles.
- Hold `instr_ready`=0 from R: exactly 2 requests issued (0, 4), `count`=2, `imem_req`=0 afterwards. Release: output 0, 4, 8 in order with no gap.
- Redirect to 32'h0000_0103 at T while a request is in flight: stale response not pushed, `imem_addr`=32'h100 at T+1, `PC`=32'h100 valid at T+3.
- Redirect coincident with pop at `count`=2: queue empty next cycle, no old PC ever reappears.
- `RESET_PC`=32'hFFFF_FFF8: PCs observed FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` mid-stream with a concurrent redirect: next cycle `instr_valid`=0, `instruction`=`NOP`, and fetch restarts at `RESET_PC`.
